// File: rtl/cmerge_sync_req_fifo.sv
// Synchronous request FIFO behind the 6-way mutex merge: synchronises the drive strobe,
// queues i_data, returns a free pulse per entry. Optional high-water mark via CMERGE_FIFO_HWM_EN.
module cmerge_sync_req_fifo #(
    parameter int unsigned DW     = 6,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned FREE_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_drive,
    input  logic [DW-1:0]            i_data,
    output logic                     o_free,
    output logic                     o_valid,
    output logic [DW-1:0]            o_data,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
`ifdef CMERGE_FIFO_HWM_EN
    input  logic                     i_hwm_clr,
    output logic [$clog2(DEPTH):0]   o_hwm,
`endif
    output logic                     o_full
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned FCW = $clog2(FREE_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_STALL, S_PUSH, S_FREE, S_WAIT_LOW} state_t;

    state_t           state_q, state_d;
    logic             drv_d1_q, drv_d2_q, drv_d3_q;
    logic [1:0]       sync_vld_q;
    logic             arm_q;
    logic [FCW-1:0]   free_cnt_q, free_cnt_d;
    logic             free_q, free_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             rise, full, push, pop;

    // A drive held across reset must be seen low once before it can be captured again;
    // sync_vld_q marks when drv_d2_q reflects the real input after the synchroniser clears.
    assign rise = drv_d2_q & ~drv_d3_q & arm_q;
    assign full = (count_q == CW'(DEPTH));
    assign pop  = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            drv_d1_q   <= 1'b0;
            drv_d2_q   <= 1'b0;
            drv_d3_q   <= 1'b0;
            sync_vld_q <= '0;
            arm_q      <= 1'b0;
            state_q    <= S_IDLE;
            free_cnt_q <= '0;
            free_q     <= 1'b0;
        end else begin
            drv_d1_q   <= i_drive;
            drv_d2_q   <= drv_d1_q;
            drv_d3_q   <= drv_d2_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            arm_q      <= arm_q | (sync_vld_q[1] & ~drv_d2_q);
            state_q    <= state_d;
            free_cnt_q <= free_cnt_d;
            free_q     <= free_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (rise) state_d = full ? S_STALL : S_PUSH;
            S_STALL:    if (!full) state_d = S_PUSH;
            S_PUSH:     state_d = S_FREE;
            S_FREE:     if (free_cnt_q <= FCW'(1)) state_d = S_WAIT_LOW;
            S_WAIT_LOW: if (!drv_d2_q) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push       = (state_q == S_PUSH);
        free_d     = (state_d == S_FREE);
        free_cnt_d = free_cnt_q;
        if (state_q == S_PUSH)
            free_cnt_d = FCW'(FREE_W);
        else if (state_q == S_FREE)
            free_cnt_d = free_cnt_q - FCW'(1);
    end

    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= i_data;
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (pop)
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop && full));
    end

`ifdef CMERGE_FIFO_HWM_EN
    logic [CW-1:0] hwm_q;

    always_ff @(posedge clk) begin
        if (rst)
            hwm_q <= '0;
        else if (i_hwm_clr)
            hwm_q <= count_q;
        else if (count_q > hwm_q)
            hwm_q <= count_q;
    end

    assign o_hwm = hwm_q;
`endif

    assign o_free  = free_q;
    assign o_valid = (count_q != '0);
    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_full  = full;

endmodule

// File: tb/tb_cmerge_sync_req_fifo.sv
// Scoreboard bench for cmerge_sync_req_fifo: expected data queued on each request,
// compared in order whenever the FIFO head is consumed.
module tb_cmerge_sync_req_fifo;

    localparam int unsigned DW     = 6;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned FREE_W = 2;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_drive;
    logic [DW-1:0] i_data;
    logic          o_free;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic [CW-1:0] o_count;
    logic          o_full;
`ifdef CMERGE_FIFO_HWM_EN
    logic          i_hwm_clr;
    logic [CW-1:0] o_hwm;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    cmerge_sync_req_fifo #(.DW(DW), .DEPTH(DEPTH), .FREE_W(FREE_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_drive (i_drive),
        .i_data  (i_data),
        .o_free  (o_free),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_count (o_count),
`ifdef CMERGE_FIFO_HWM_EN
        .i_hwm_clr (i_hwm_clr),
        .o_hwm     (o_hwm),
`endif
        .o_full  (o_full)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A pop happens on the next rising edge whenever o_valid & i_ready hold at the falling edge.
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0)
                check_val("sb_underflow", 32'd1, 32'd0);
            else
                check_val("fifo_data", 32'(o_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_free();
        for (int k = 0; k < 100; k++) begin
            if (o_free) break;
            tick();
        end
        check_val("free_seen", 32'(o_free), 32'd1);
    endtask

    task automatic req_handshake(input logic [DW-1:0] d);
        i_data  = d;
        i_drive = 1'b1;
        exp_q.push_back(d);
        wait_free();
        for (int k = 0; k < int'(FREE_W) + 2; k++) begin
            if (!o_free) break;
            tick();
        end
        i_drive = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drain_until(input int n);
        i_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (int'(o_count) == n) break;
            tick();
        end
        i_ready = 1'b0;
        check_val("drain_to", 32'(o_count), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; i_drive = 1'b0; i_data = '0; i_ready = 1'b0;
`ifdef CMERGE_FIFO_HWM_EN
        i_hwm_clr = 1'b0;
`endif
        repeat (3) tick();
        check_val("rst_free",  32'(o_free),  32'd0);
        check_val("rst_valid", 32'(o_valid), 32'd0);
        check_val("rst_data",  32'(o_data),  32'd0);
        check_val("rst_count", 32'(o_count), 32'd0);
        check_val("rst_full",  32'(o_full),  32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // Single request with exact latency: push at N+3, free N+4..N+5
        i_ready = 1'b1; i_data = 6'h2A; i_drive = 1'b1; exp_q.push_back(6'h2A);
        repeat (3) tick();
        check_val("lat_valid_n3", 32'(o_valid), 32'd0);
        check_val("lat_free_n3",  32'(o_free),  32'd0);
        tick();
        check_val("lat_valid_n4", 32'(o_valid), 32'd1);
        check_val("lat_data_n4",  32'(o_data),  32'h2A);
        check_val("lat_count_n4", 32'(o_count), 32'd1);
        check_val("lat_free_n4",  32'(o_free),  32'd1);
        tick();
        check_val("lat_free_n5",  32'(o_free),  32'd1);
        check_val("lat_count_n5", 32'(o_count), 32'd0);
        tick();
        check_val("lat_free_n6",  32'(o_free),  32'd0);
        i_drive = 1'b0; i_ready = 1'b0;
        repeat (4) tick();

        // Fill and stall
        for (int i = 1; i <= 4; i++) req_handshake(DW'(i));
        check_val("fill_count", 32'(o_count), 32'd4);
        check_val("fill_full",  32'(o_full),  32'd1);
        i_data = 6'h05; i_drive = 1'b1; exp_q.push_back(6'h05);
        repeat (8) tick();
        check_val("stall_free",  32'(o_free),  32'd0);
        check_val("stall_count", 32'(o_count), 32'd4);
        i_ready = 1'b1; tick(); i_ready = 1'b0;
        check_val("stall_pop_count", 32'(o_count), 32'd3);
        wait_free();
        check_val("stall_push_count", 32'(o_count), 32'd4);
        while (o_free) tick();
        i_drive = 1'b0;
        repeat (4) tick();
        drain_until(0);

        // Stalled push firing on the same edge as a pop
        for (int i = 6; i <= 9; i++) req_handshake(DW'(i));
        i_data = 6'h0A; i_drive = 1'b1; exp_q.push_back(6'h0A);
        repeat (6) tick();
        i_ready = 1'b1; tick(); i_ready = 1'b0;
        check_val("pp_after_pop", 32'(o_count), 32'd3);
        tick();
        check_val("pp_in_push",   32'(o_count), 32'd3);
        check_val("pp_free_pre",  32'(o_free),  32'd0);
        i_ready = 1'b1; tick(); i_ready = 1'b0;
        check_val("pp_same_edge", 32'(o_count), 32'd3);
        check_val("pp_free",      32'(o_free),  32'd1);
        while (o_free) tick();
        i_drive = 1'b0;
        repeat (4) tick();
        drain_until(0);

        // Pointer wrap with continuous draining
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) req_handshake(DW'(i));
        i_ready = 1'b0;
        check_val("wrap_empty", 32'(exp_q.size()), 32'd0);
        check_val("wrap_count", 32'(o_count), 32'd0);

        // Reset while the third entry is being freed
        req_handshake(6'h11);
        req_handshake(6'h12);
        i_data = 6'h13; i_drive = 1'b1; exp_q.push_back(6'h13);
        wait_free();
        check_val("mid_count_pre", 32'(o_count), 32'd3);
        rst = 1'b1; tick();
        check_val("mid_free",  32'(o_free),  32'd0);
        check_val("mid_valid", 32'(o_valid), 32'd0);
        check_val("mid_count", 32'(o_count), 32'd0);
        check_val("mid_data",  32'(o_data),  32'd0);
        exp_q.delete();
        rst = 1'b0;
        repeat (10) tick();
        check_val("held_drive_count", 32'(o_count), 32'd0);
        check_val("held_drive_free",  32'(o_free),  32'd0);
        i_drive = 1'b0;
        repeat (4) tick();
        i_ready = 1'b1;
        req_handshake(6'h21);
        i_ready = 1'b0;
        check_val("recapture_empty", 32'(exp_q.size()), 32'd0);

`ifdef CMERGE_FIFO_HWM_EN
        for (int i = 0; i < 3; i++) req_handshake(DW'(6'h30 + i));
        drain_until(1);
        tick();
        check_val("hwm_peak", 32'(o_hwm), 32'd3);
        i_hwm_clr = 1'b1; tick(); i_hwm_clr = 1'b0;
        tick();
        check_val("hwm_clr", 32'(o_hwm), 32'd1);
        drain_until(0);
`endif

        check_val("final_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
